// File: rtl/wb_exmem_pkg.sv
// wb_exmem_pkg: shared FSM encoding and sizing helpers for the prefetching external-memory emulator.
package wb_exmem_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, WRITE, FILL, ACK} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int LINE_WORDS = 4;
    localparam int ADDR_WIDTH = 12;
    localparam int OFF_W      = clog2(LINE_WORDS);
    localparam int TAG_W      = ADDR_WIDTH - OFF_W;

endpackage

// File: rtl/wb_exmem_prefetch_bram_sp.sv
// bram_sp: single-port byte-enable synchronous RAM, read-first, one-cycle read latency.
module bram_sp #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            sel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdat,
    output logic [31:0]           rdat
);
    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we && sel[i]) mem[addr][8*i +: 8] <= wdat[8*i +: 8];
        rdat <= mem[addr];
    end
endmodule

// File: rtl/wb_exmem_prefetch.sv
// wb_exmem_prefetch: Wishbone slave emulating slow memory with a one-line read prefetch buffer.
module wb_exmem_prefetch
    import wb_exmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter int          ADDR_WIDTH  = 12,
    parameter int          DELAYS      = 10,
    parameter int          LINE_WORDS  = 4,
    parameter bit          PREFETCH_EN = 1'b1,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_adr_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [CNT_WIDTH-1:0] hit_cnt_o,
    output logic [CNT_WIDTH-1:0] miss_cnt_o
);
    localparam int OW = clog2(LINE_WORDS);
    localparam int AW = ADDR_WIDTH;
    localparam int CW = clog2(DELAYS + 2);
    localparam logic [CW-1:0] WAIT_LOAD = CW'((DELAYS > 0) ? DELAYS - 1 : 0);
    localparam logic [31:0] WIN_MASK = ~((32'd4 << ADDR_WIDTH) - 32'd1);

    state_t state, next;
    logic [31:0] line [LINE_WORDS];
    logic [AW-OW-1:0] tag_q;
    logic valid;
    logic [AW-1:0] addr_q, bram_addr;
    logic we_q, abort_q;
    logic [3:0] sel_q;
    logic [31:0] wdat_q, rdat, fill_word;
    logic [CW-1:0] cnt;
    logic [OW:0] fcnt;
    logic req, hit, fill_last;
    logic [AW-1:0] in_word;

    assign in_word   = wbs_adr_i[AW+1:2];
    assign req       = wbs_cyc_i && wbs_stb_i && ((wbs_adr_i & WIN_MASK) == BASE_ADDR);
    assign hit       = req && !wbs_we_i && PREFETCH_EN && valid && tag_q == in_word[AW-1:OW];
    assign fill_last = PREFETCH_EN ? fcnt == (OW+1)'(LINE_WORDS) : 1'b1;
    // The last fill word lands in the buffer this cycle, so take it straight from the RAM.
    assign fill_word = (!PREFETCH_EN || addr_q[OW-1:0] == OW'(LINE_WORDS - 1)) ? rdat : line[addr_q[OW-1:0]];
    assign bram_addr = (state == IDLE) ? in_word :
                       (state == FILL && PREFETCH_EN) ? {addr_q[AW-1:OW], fcnt[OW-1:0]} : addr_q;

    bram_sp #(.ADDR_WIDTH(AW)) u_bram (
        .clk  (wb_clk_i),
        .we   (state == WRITE),
        .sel  (sel_q),
        .addr (bram_addr),
        .wdat (wdat_q),
        .rdat (rdat)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !req ? IDLE : hit ? ACK : (DELAYS > 0) ? WAIT : wbs_we_i ? WRITE : FILL;
            WAIT:    next = !wbs_cyc_i ? IDLE : (cnt != '0) ? WAIT : we_q ? WRITE : FILL;
            WRITE:   next = ACK;
            FILL:    next = !fill_last ? FILL : (abort_q || !wbs_cyc_i) ? IDLE : ACK;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            valid      <= 1'b0;
            tag_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            cnt        <= '0;
            fcnt       <= '0;
            abort_q    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            wbs_ack_o <= next == ACK;
            wbs_dat_o <= '0;
            if (state == IDLE && req) begin
                addr_q  <= in_word;
                we_q    <= wbs_we_i;
                sel_q   <= wbs_sel_i;
                wdat_q  <= wbs_dat_i;
                cnt     <= WAIT_LOAD;
                fcnt    <= '0;
                abort_q <= 1'b0;
            end
            if (state == IDLE && hit) begin
                wbs_dat_o <= line[in_word[OW-1:0]];
                hit_cnt_o <= hit_cnt_o + {{(CNT_WIDTH-1){1'b0}}, ~&hit_cnt_o};
            end
            if (state == WAIT) cnt <= cnt - 1'b1;
            if (state == FILL) begin
                fcnt    <= fcnt + 1'b1;
                abort_q <= abort_q || !wbs_cyc_i;
                if (fill_last && PREFETCH_EN) begin
                    valid      <= 1'b1;
                    tag_q      <= addr_q[AW-1:OW];
                    miss_cnt_o <= miss_cnt_o + {{(CNT_WIDTH-1){1'b0}}, ~&miss_cnt_o};
                end
                if (next == ACK) wbs_dat_o <= fill_word;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (state == FILL && PREFETCH_EN && fcnt != '0) line[fcnt[OW-1:0] - 1'b1] <= rdat;
        if (state == WRITE && valid && tag_q == addr_q[AW-1:OW])
            for (int i = 0; i < 4; i++)
                if (sel_q[i]) line[addr_q[OW-1:0]][8*i +: 8] <= wdat_q[8*i +: 8];
    end
endmodule

// File: tb/tb_wb_exmem_prefetch.sv
// tb_wb_exmem_prefetch: directed latency/data checks for the prefetching memory slave.
module tb_wb_exmem_prefetch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] cyc = '0, stb = '0;
    logic we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] wdat = '0, adr = '0;
    logic ack [2];
    logic [31:0] rd [2];
    logic [15:0] hitc [2], missc [2];
    int compared = 0, mismatched = 0;

    wb_exmem_prefetch #(.PREFETCH_EN(1'b1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack[0]), .wbs_dat_o(rd[0]), .hit_cnt_o(hitc[0]), .miss_cnt_o(missc[0])
    );

    wb_exmem_prefetch #(.PREFETCH_EN(1'b0)) dut_np (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack[1]), .wbs_dat_o(rd[1]), .hit_cnt_o(hitc[1]), .miss_cnt_o(missc[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency n means ack seen in cycle k+n; -1 means no ack within the limit.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int limit, input int abort_at, input int rst_at,
                        output int lat, output logic [31:0] r);
        lat = -1;
        r = '0;
        @(posedge clk); #1;
        we = w; adr = a; wdat = wd; sel = s; cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (ack[d]) begin
                lat = n;
                r = rd[d];
                break;
            end
            if (n == abort_at) cyc[d] = 1'b0;
            if (n == rst_at) begin
                rst = 1'b1;
                cyc[d] = 1'b0;
                stb[d] = 1'b0;
                #1;
                check("rst_ack", 32'(ack[d]), 32'd0);
                check("rst_hit", 32'(hitc[d]), 32'd0);
                check("rst_miss", 32'(missc[d]), 32'd0);
            end
            if (rst_at > 0 && n == rst_at + 1) rst = 1'b0;
        end
        cyc[d] = 1'b0;
        stb[d] = 1'b0;
        if (lat > 0) begin
            @(posedge clk); #1;
            check("ack_one_cycle", 32'(ack[d]), 32'd0);
            check("dat_idle", rd[d], 32'd0);
        end
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                      input int exp_lat, input string tag);
        int lat;
        logic [31:0] r;
        xfer(d, 1'b1, a, wd, s, 60, 0, 0, lat, r);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dat"}, r, 32'd0);
    endtask

    task automatic rdc(input int d, input logic [31:0] a, input int exp_lat, input logic [31:0] exp_dat,
                       input string tag);
        int lat;
        logic [31:0] r;
        xfer(d, 1'b0, a, 32'd0, 4'h0, 60, 0, 0, lat, r);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_dat"}, r, exp_dat);
    endtask

    initial begin
        int lat;
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack[0]), 32'd0);
        check("reset_dat", rd[0], 32'd0);
        check("reset_hit", 32'(hitc[0]), 32'd0);
        check("reset_miss", 32'(missc[0]), 32'd0);
        rst = 1'b0;

        wr(0, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, 12, "wr10");
        check("wr_miss_cnt", 32'(missc[0]), 32'd0);
        wr(0, 32'h3800_0014, 32'h1122_3344, 4'hF, 12, "wr14");
        wr(0, 32'h3800_0018, 32'h5566_7788, 4'hF, 12, "wr18");
        wr(0, 32'h3800_001C, 32'h99AA_BBCC, 4'hF, 12, "wr1c");

        rdc(0, 32'h3800_0010, 16, 32'hDEAD_BEEF, "rd10_miss");
        check("miss_cnt1", 32'(missc[0]), 32'd1);
        rdc(0, 32'h3800_0014, 1, 32'h1122_3344, "rd14_hit");
        check("hit_cnt1", 32'(hitc[0]), 32'd1);

        wr(0, 32'h3800_0014, 32'h0000_AB00, 4'b0010, 12, "wr14_byte1");
        rdc(0, 32'h3800_0014, 1, 32'h1122_AB44, "rd14_through");
        rdc(0, 32'h3800_001F, 1, 32'h99AA_BBCC, "rd1c_hit");
        check("hit_cnt3", 32'(hitc[0]), 32'd3);

        xfer(0, 1'b0, 32'h3000_0000, 32'd0, 4'h0, 50, 0, 0, lat, r);
        check("oow_lat", 32'(lat), 32'hFFFF_FFFF);
        check("oow_hit", 32'(hitc[0]), 32'd3);
        check("oow_miss", 32'(missc[0]), 32'd1);
        rdc(0, 32'h3800_0018, 1, 32'h5566_7788, "rd18_after_oow");

        wr(0, 32'h3800_0020, 32'hCAFE_F00D, 4'hF, 12, "wr20");
        xfer(0, 1'b1, 32'h3800_0020, 32'h1234_5678, 4'hF, 60, 5, 0, lat, r);
        check("wr_abort_lat", 32'(lat), 32'hFFFF_FFFF);
        rdc(0, 32'h3800_0020, 16, 32'hCAFE_F00D, "rd20_prior");
        check("miss_cnt2", 32'(missc[0]), 32'd2);

        xfer(0, 1'b0, 32'h3800_0010, 32'd0, 4'h0, 60, 13, 0, lat, r);
        check("fill_abort_lat", 32'(lat), 32'hFFFF_FFFF);
        check("fill_abort_miss", 32'(missc[0]), 32'd3);
        rdc(0, 32'h3800_0010, 1, 32'hDEAD_BEEF, "rd10_after_abort");
        check("hit_cnt5", 32'(hitc[0]), 32'd5);

        xfer(0, 1'b0, 32'h3800_0020, 32'd0, 4'h0, 30, 0, 13, lat, r);
        check("rst_fill_lat", 32'(lat), 32'hFFFF_FFFF);
        rdc(0, 32'h3800_0020, 16, 32'hCAFE_F00D, "rd20_after_rst");
        check("post_rst_miss", 32'(missc[0]), 32'd1);
        check("post_rst_hit", 32'(hitc[0]), 32'd0);

        wr(1, 32'h3800_0040, 32'hA5A5_A5A5, 4'hF, 12, "np_wr40");
        rdc(1, 32'h3800_0040, 12, 32'hA5A5_A5A5, "np_rd40");
        rdc(1, 32'h3800_0040, 12, 32'hA5A5_A5A5, "np_rd40_again");
        wr(1, 32'h3800_3FFC, 32'h0BAD_C0DE, 4'hF, 12, "np_wr_top");
        rdc(1, 32'h3800_3FFC, 12, 32'h0BAD_C0DE, "np_rd_top");
        xfer(1, 1'b0, 32'h3800_4000, 32'd0, 4'h0, 20, 0, 0, lat, r);
        check("np_oow_lat", 32'(lat), 32'hFFFF_FFFF);
        check("np_hit", 32'(hitc[1]), 32'd0);
        check("np_miss", 32'(missc[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
